// File: rtl/accel_pkg.sv
// accel_pkg: lane count and lane-index type shared by the demux slice.
package accel_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_SEL_W = 2;
  typedef logic [LANE_SEL_W-1:0] lane_t;
endpackage

// File: rtl/demux4_buf_if.sv
// demux4_buf_if: input word stream plus four registered output lanes.
interface demux4_buf_if
  import accel_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  lane_t in_sel;
  logic in_valid;
  logic in_ready;
  logic rr_en;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [NUM_LANES-1:0] out_valid;
  logic [NUM_LANES-1:0] out_ready;
  lane_t rr_ptr;
  logic busy;
  modport master (
    output in_data, in_sel, in_valid, rr_en, out_ready,
    input in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, rr_ptr, busy
  );
  modport slave (
    input in_data, in_sel, in_valid, rr_en, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, rr_ptr, busy
  );
endinterface

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one-entry valid/data slot; a load on the draining edge keeps the lane full.
module demux_lane_reg #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] load_data,
  input  logic out_ready,
  output logic out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic can_accept
);
  assign can_accept = ~out_valid | out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: registered 1-to-4 stream demux with explicit or round-robin lane select.
module demux4_buf
  import accel_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  demux4_buf_if.slave bus
);
  lane_t tgt, rr_ptr_q;
  logic accept;
  logic [NUM_LANES-1:0] load, can_accept, valid;
  logic [WIDTH-1:0] data [NUM_LANES];
  assign tgt = bus.rr_en ? rr_ptr_q : bus.in_sel;
  assign bus.in_ready = can_accept[tgt];
  assign accept = bus.in_valid & bus.in_ready;
  assign load = accept ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << tgt) : '0;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk(clk),
      .rst(rst),
      .load(load[i]),
      .load_data(bus.in_data),
      .out_ready(bus.out_ready[i]),
      .out_valid(valid[i]),
      .out_data(data[i]),
      .can_accept(can_accept[i])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else if (accept && bus.rr_en) rr_ptr_q <= rr_ptr_q + 1'b1;
  end
  assign bus.out_valid = valid;
  assign bus.busy = |valid;
  assign bus.rr_ptr = rr_ptr_q;
  assign bus.out_data0 = data[0];
  assign bus.out_data1 = data[1];
  assign bus.out_data2 = data[2];
  assign bus.out_data3 = data[3];
endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: directed vectors with hand-computed expectations for demux4_buf.
module tb_demux4_buf;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  demux4_buf_if #(.WIDTH(16)) bus ();
  demux4_buf #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic [1:0] s);
    bus.in_data = d;
    bus.in_sel = s;
    bus.in_valid = 1'b1;
  endtask
  function automatic logic [15:0] lane_data(input int i);
    return i == 0 ? bus.out_data0 : i == 1 ? bus.out_data1 : i == 2 ? bus.out_data2 : bus.out_data3;
  endfunction
  initial begin
    rst = 1'b1;
    bus.in_data = '0;
    bus.in_sel = '0;
    bus.in_valid = 1'b0;
    bus.rr_en = 1'b0;
    bus.out_ready = 4'b0000;
    step();
    step();
    chk("rst_valid", bus.out_valid, 4'b0000);
    chk("rst_ptr", bus.rr_ptr, 2'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    step();
    // directed select, all consumers ready
    bus.out_ready = 4'b1111;
    send(16'h1111, 2'd0);
    #1 chk("dir_rdy0", bus.in_ready, 1'b1);
    step();
    chk("dir_v0", bus.out_valid, 4'b0001);
    chk("dir_d0", lane_data(0), 16'h1111);
    send(16'h2222, 2'd3);
    #1 chk("dir_rdy3", bus.in_ready, 1'b1);
    step();
    chk("dir_v3", bus.out_valid, 4'b1000);
    chk("dir_d3", lane_data(3), 16'h2222);
    send(16'h3333, 2'd1);
    #1 chk("dir_rdy1", bus.in_ready, 1'b1);
    step();
    chk("dir_v1", bus.out_valid, 4'b0010);
    chk("dir_d1", lane_data(1), 16'h3333);
    chk("dir_busy", bus.busy, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk("dir_drain", bus.out_valid, 4'b0000);
    // backpressure on lane 2
    bus.out_ready = 4'b0000;
    send(16'hAAAA, 2'd2);
    step();
    chk("bp_v", bus.out_valid, 4'b0100);
    chk("bp_d2", lane_data(2), 16'hAAAA);
    send(16'hBBBB, 2'd2);
    #1 chk("bp_stall", bus.in_ready, 1'b0);
    step();
    chk("bp_hold_v", bus.out_valid, 4'b0100);
    chk("bp_hold_d", lane_data(2), 16'hAAAA);
    send(16'hCCCC, 2'd0);
    #1 chk("bp_other_rdy", bus.in_ready, 1'b1);
    step();
    chk("bp_other_v", bus.out_valid, 4'b0101);
    chk("bp_other_d", lane_data(0), 16'hCCCC);
    send(16'hDDDD, 2'd2);
    bus.out_ready = 4'b0100;
    #1 chk("bp_release_rdy", bus.in_ready, 1'b1);
    step();
    chk("bp_replace_v", bus.out_valid, 4'b0101);
    chk("bp_replace_d", lane_data(2), 16'hDDDD);
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b1111;
    step();
    chk("bp_drain", bus.out_valid, 4'b0000);
    // round-robin over six words
    bus.rr_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(16'(k), 2'd3);
      step();
      chk("rr_v", bus.out_valid, 32'(1 << (k % 4)));
      chk("rr_d", lane_data(k % 4), 32'(k));
    end
    bus.in_valid = 1'b0;
    chk("rr_ptr_end", bus.rr_ptr, 2'd2);
    step();
    // reset mid-transfer with lane 2 holding a word
    bus.rr_en = 1'b0;
    bus.out_ready = 4'b0000;
    send(16'h1234, 2'd2);
    step();
    bus.in_valid = 1'b0;
    chk("mid_v", bus.out_valid, 4'b0100);
    chk("mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_v", bus.out_valid, 4'b0000);
    chk("mid_rst_ptr", bus.rr_ptr, 2'd0);
    chk("mid_rst_rdy", bus.in_ready, 1'b1);
    chk("mid_rst_busy", bus.busy, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_v", bus.out_valid, 4'b0000);
    chk("post_rst_rdy", bus.in_ready, 1'b1);
    // round-robin stall: pointer at 1 with lane 1 full
    bus.rr_en = 1'b1;
    bus.out_ready = 4'b1111;
    send(16'h4444, 2'd0);
    step();
    chk("st_ptr1", bus.rr_ptr, 2'd1);
    bus.rr_en = 1'b0;
    bus.out_ready = 4'b0000;
    send(16'h5555, 2'd1);
    step();
    chk("st_fill_v", bus.out_valid, 4'b0011);
    bus.rr_en = 1'b1;
    send(16'h6666, 2'd3);
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_rdy", bus.in_ready, 1'b0);
      step();
      chk("st_ptr_hold", bus.rr_ptr, 2'd1);
      chk("st_d1_hold", lane_data(1), 16'h5555);
    end
    bus.out_ready = 4'b0010;
    #1 chk("st_release_rdy", bus.in_ready, 1'b1);
    step();
    chk("st_acc_d", lane_data(1), 16'h6666);
    chk("st_acc_v", bus.out_valid, 4'b0011);
    chk("st_ptr2", bus.rr_ptr, 2'd2);
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b1111;
    step();
    chk("st_drain", bus.out_valid, 4'b0000);
    // mode switch at pointer 3
    send(16'h8888, 2'd0);
    step();
    chk("ms_v2", bus.out_valid, 4'b0100);
    chk("ms_ptr3", bus.rr_ptr, 2'd3);
    bus.rr_en = 1'b0;
    send(16'h9999, 2'd0);
    step();
    chk("ms_sel_v", bus.out_valid, 4'b0001);
    chk("ms_sel_d", lane_data(0), 16'h9999);
    chk("ms_ptr_hold", bus.rr_ptr, 2'd3);
    bus.rr_en = 1'b1;
    send(16'hAAAB, 2'd0);
    step();
    chk("ms_rr_v", bus.out_valid, 4'b1000);
    chk("ms_rr_d", lane_data(3), 16'hAAAB);
    chk("ms_wrap", bus.rr_ptr, 2'd0);
    bus.in_valid = 1'b0;
    step();
    chk("end_idle", bus.busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
